// File: rtl/irrigation_actuator_pkg.sv
// Shared encodings for the irrigation controller and its actuator stage.
package irrigation_actuator_pkg;

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_SPR  = 2'b01;
   localparam logic [1:0] MODE_DRIP = 2'b10;
   localparam logic [1:0] MODE_FILL = 2'b11;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_DEAD  = 2'b01,
      ST_ON    = 2'b10,
      ST_FAULT = 2'b11
   } fsm_e;

endpackage

// File: rtl/irrigation_actuator_tick_counter.sv
// Enabled, synchronously clearable up-counter that holds at all-ones.
module tick_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         initialize,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (initialize)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/irrigation_actuator.sv
// Pump/valve driver with break-before-make dead time, on-time watchdog and mode-change count.
//   state    | meaning
//   ST_OFF   | idle, all actuators off
//   ST_DEAD  | dead time between modes, all actuators off
//   ST_ON    | actuators follow cmd_q, run-time watchdog active
//   ST_FAULT | watchdog tripped, everything off until initialize
module irrigation_actuator
   import irrigation_actuator_pkg::*;
#(
   parameter int DEAD_TICKS   = 2,
   parameter int MAX_ON_TICKS = 60,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             initialize,
   input  logic [1:0]       state,
   input  logic             transition,
   input  logic             tick,
   output logic             pump_en,
   output logic             valve_spr,
   output logic             valve_drip,
   output logic             valve_fill,
   output logic [CNT_W-1:0] run_ticks,
   output logic [7:0]       sw_count,
   output logic             fault
);

   localparam logic [8:0]     DEAD_LAST = 9'(DEAD_TICKS);
   localparam logic [CNT_W:0] RUN_LAST  = (CNT_W+1)'(MAX_ON_TICKS);

   fsm_e       state_q, state_d;
   logic [1:0] cmd_q;
   logic [7:0] dead_cnt;
   logic       dead_clr, dead_en, run_clr, run_en, cmd_load;
   logic       dead_done, wd_trip, on_q;

   assign dead_done = tick && (({1'b0, dead_cnt} + 9'd1) == DEAD_LAST);
   assign wd_trip   = tick && (({1'b0, run_ticks} + 1'b1) == RUN_LAST);
   assign dead_en   = tick && (state_q == ST_DEAD);
   assign run_en    = tick && (state_q == ST_ON);
   assign on_q      = (state_q == ST_ON);

   always_comb begin
      state_d  = state_q;
      dead_clr = 1'b0;
      run_clr  = 1'b0;
      cmd_load = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (transition || ((state != MODE_IDLE) && (cmd_q == MODE_IDLE))) begin
               state_d  = ST_DEAD;
               dead_clr = 1'b1;
            end
         end
         ST_DEAD: begin
            // a fresh transition restarts the dead time even on a completing tick
            if (transition) begin
               dead_clr = 1'b1;
            end else if (dead_done) begin
               cmd_load = 1'b1;
               if (state != MODE_IDLE) begin
                  state_d = ST_ON;
                  run_clr = 1'b1;
               end else begin
                  state_d = ST_OFF;
               end
            end
         end
         ST_ON: begin
            if (transition || (state != cmd_q)) begin
               state_d  = ST_DEAD;
               dead_clr = 1'b1;
            end else if (wd_trip) begin
               state_d = ST_FAULT;
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (initialize) begin
         state_q    <= ST_OFF;
         cmd_q      <= MODE_IDLE;
         sw_count   <= 8'd0;
         pump_en    <= 1'b0;
         valve_spr  <= 1'b0;
         valve_drip <= 1'b0;
         valve_fill <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cmd_load)
            cmd_q <= state;
         if (transition && (sw_count != 8'hFF))
            sw_count <= sw_count + 8'd1;
         pump_en    <= on_q && ((cmd_q == MODE_SPR) || (cmd_q == MODE_DRIP));
         valve_spr  <= on_q && (cmd_q == MODE_SPR);
         valve_drip <= on_q && (cmd_q == MODE_DRIP);
         valve_fill <= on_q && (cmd_q == MODE_FILL);
         fault      <= (state_q == ST_FAULT);
      end
   end

   tick_counter #(.W(8)) u_dead_cnt (
      .clk        (clk),
      .initialize (initialize),
      .clr        (dead_clr),
      .en         (dead_en),
      .count      (dead_cnt)
   );

   tick_counter #(.W(CNT_W)) u_run_cnt (
      .clk        (clk),
      .initialize (initialize),
      .clr        (run_clr),
      .en         (run_en),
      .count      (run_ticks)
   );

endmodule
